arm_ctrl_pipe: RTL

Parametrised successor to the ID-stage control decoder of the ARM core. Decodes mode/opcode/S in ID and inserts a bubble on hazard, failed condition or branch flush. It then carries the resulting control word through registered EX, MEM and WB pipeline slots. A whole-pipe freeze is driven by the cache miss path. Sits between the hazard unit/condition check in ID and the EX/MEM/WB datapath registers.

---
 rtl/arm_ctrl_pipe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/arm_ctrl_pipe.sv
// arm_ctrl_pipe: ID control decode with bubble insertion, carried through EX/MEM/WB slots.
// Optional CTRL_PERF_CNT_EN adds saturating bubble/flush counters.
module arm_ctrl_pipe #(
  parameter int CMD_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             flush,
  input  logic             hazard,
  input  logic             cond_pass,
  input  logic             id_valid,
  input  logic [1:0]       mode,
  input  logic [3:0]       opcode,
  input  logic             s_in,
  output logic             id_wb_en,
  output logic             ex_valid,
  output logic             ex_wb_en,
  output logic             ex_mem_r_en,
  output logic             ex_mem_w_en,
  output logic             ex_b,
  output logic             ex_s,
  output logic [CMD_W-1:0] ex_cmd,
  output logic             mem_valid,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             mem_wb_en,
  output logic             wb_valid,
  output logic             wb_en,
  output logic             wb_from_mem
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  logic [3:0] w_c;
  logic       w_wb, w_mr, w_mw, w_b, w_s, w_ok;

  always_comb begin
    w_c  = 4'd0;
    w_wb = 1'b0;
    w_mr = 1'b0;
    w_mw = 1'b0;
    w_b  = 1'b0;
    w_s  = 1'b0;
    case (mode)
      2'b00: begin
        w_s  = s_in;
        w_wb = 1'b1;
        case (opcode)
          4'b1101: w_c = 4'b0001;
          4'b1111: w_c = 4'b1001;
          4'b0100: w_c = 4'b0010;
          4'b0101: w_c = 4'b0011;
          4'b0010: w_c = 4'b0100;
          4'b0110: w_c = 4'b0101;
          4'b0000: w_c = 4'b0110;
          4'b1100: w_c = 4'b0111;
          4'b0001: w_c = 4'b1000;
          4'b1010: begin w_c = 4'b0100; w_wb = 1'b0; w_s = 1'b1; end
          4'b1000: begin w_c = 4'b0110; w_wb = 1'b0; w_s = 1'b1; end
          default: begin w_wb = 1'b0; w_s = 1'b0; end
        endcase
      end
      2'b01: begin
        w_c  = 4'b0010;
        w_mr = s_in;
        w_wb = s_in;
        w_mw = ~s_in;
      end
      2'b10: w_b = 1'b1;
      default: ;
    endcase
  end

  assign id_wb_en = w_wb;
  assign w_ok     = id_valid & cond_pass & ~hazard & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_wb_en    <= 1'b0;
      ex_mem_r_en <= 1'b0;
      ex_mem_w_en <= 1'b0;
      ex_b        <= 1'b0;
      ex_s        <= 1'b0;
      ex_cmd      <= '0;
      mem_valid   <= 1'b0;
      mem_r_en    <= 1'b0;
      mem_w_en    <= 1'b0;
      mem_wb_en   <= 1'b0;
      wb_valid    <= 1'b0;
      wb_en       <= 1'b0;
      wb_from_mem <= 1'b0;
    end else if (!freeze) begin
      ex_valid    <= w_ok;
      ex_wb_en    <= w_ok & w_wb;
      ex_mem_r_en <= w_ok & w_mr;
      ex_mem_w_en <= w_ok & w_mw;
      ex_b        <= w_ok & w_b;
      ex_s        <= w_ok & w_s;
      ex_cmd      <= w_ok ? CMD_W'(w_c) : '0;
      mem_valid   <= ex_valid;
      mem_r_en    <= ex_mem_r_en;
      mem_w_en    <= ex_mem_w_en;
      mem_wb_en   <= ex_wb_en;
      wb_valid    <= mem_valid;
      wb_en       <= mem_wb_en;
      wb_from_mem <= mem_r_en;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic w_bub, w_fl;
  // flush takes precedence: a flushed slot is never also counted as a bubble
  assign w_bub = id_valid & (hazard | ~cond_pass) & ~flush;
  assign w_fl  = id_valid & flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (!freeze) begin
      bubble_cnt <= bubble_cnt + CNT_W'(w_bub & ~&bubble_cnt);
      flush_cnt  <= flush_cnt + CNT_W'(w_fl & ~&flush_cnt);
    end
  end
`endif
endmodule
